// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and flag control for the UART receive FIFO
//
// Purpose: tracks write/read pointers and occupancy for a circular buffer of
// 2**addr_bits entries, and decodes empty/full/almost_full from the next-state
// count so the flags change in the same cycle as count.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   wr_tick, rd             write and read strobes from outside
//   we                      storage write enable (write accepted this cycle)
//   drop                    write attempted while full without a pop
//   wr_addr, rd_addr        storage write / read addresses
//   count                   occupancy 0..2**addr_bits
//   empty, full, almost_full registered status flags
module fifo_ctrl #(
    parameter int addr_bits = 4,
    parameter int af_level  = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_tick,
    input  logic                 rd,
    output logic                 we,
    output logic                 drop,
    output logic [addr_bits-1:0] wr_addr,
    output logic [addr_bits-1:0] rd_addr,
    output logic [addr_bits:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full
);

    localparam logic [addr_bits-1:0] ptr_one  = {{(addr_bits-1){1'b0}}, 1'b1};
    localparam logic [addr_bits:0]   cnt_one  = {{addr_bits{1'b0}}, 1'b1};
    localparam logic [addr_bits:0]   cnt_full = {1'b1, {addr_bits{1'b0}}};
    localparam logic [addr_bits:0]   af_thr   = af_level[addr_bits:0];

    logic [addr_bits-1:0] wr_ptr;
    logic [addr_bits-1:0] rd_ptr;
    logic                 do_rd;
    logic [addr_bits:0]   count_nxt;

    // A pop frees the slot the push lands in, so a write is allowed while
    // full as long as a read happens in the same cycle.
    always_comb begin
        we        = wr_tick & (~full | rd);
        do_rd     = rd & ~empty;
        drop      = wr_tick & full & ~rd;
        count_nxt = count;
        case ({we, do_rd})
            2'b10:   count_nxt = count + cnt_one;
            2'b01:   count_nxt = count - cnt_one;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (we)
                wr_ptr <= wr_ptr + ptr_one;
            if (do_rd)
                rd_ptr <= rd_ptr + ptr_one;
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == cnt_full);
            almost_full <= (count_nxt >= af_thr);
        end
    end

    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive buffer behind the UART receiver
//
// Purpose: stores each received character on the receiver done tick and holds
// it until the host reads it; head entry is always visible on rd_data.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   wr_tick, wr_data   character strobe and data from the receiver
//   rd                 pop the head entry
//   rd_data            head entry (stable but meaningless when empty)
//   empty, full, almost_full, count   occupancy status
//   overflow           sticky flag: a character was dropped while full
//   clr_overflow       clears overflow (a simultaneous drop keeps it set)
module uart_rx_fifo #(
    parameter int data_bits = 8,
    parameter int addr_bits = 4,
    parameter int af_level  = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_tick,
    input  logic [data_bits-1:0] wr_data,
    input  logic                 rd,
    output logic [data_bits-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic [addr_bits:0]   count,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    localparam int depth = 2 ** addr_bits;

    logic [data_bits-1:0] mem [depth];
    logic                 we;
    logic                 drop;
    logic [addr_bits-1:0] wr_addr;
    logic [addr_bits-1:0] rd_addr;

    fifo_ctrl #(
        .addr_bits (addr_bits),
        .af_level  (af_level)
    ) u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_tick     (wr_tick),
        .rd          (rd),
        .we          (we),
        .drop        (drop),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each completed character on the receiver's one-cycle done pulse and holds it in a circular buffer until the host side reads it.
- Data is presented first-word-fall-through.
- Provides occupancy, an almost-full flag for RTS-style flow control, and a sticky overflow flag for dropped characters.

Parameters:
data_bits, 8, width of each stored character; matches the receiver's data width
addr_bits, 4, pointer width; depth = 2**addr_bits entries (default 16)
af_level, 12, almost_full asserts when count >= af_level; legal range 1..2**addr_bits

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
wr_tick  input  1  write strobe, one clk wide; driven by the receiver done tick
wr_data  input  data_bits  character written when wr_tick=1
rd  input  1  read strobe; pops the head entry
rd_data  output  data_bits  head entry (FWFT); undefined-but-stable when empty
empty  output  1  no entries held
full  output  1  2**addr_bits entries held
almost_full  output  1  count >= af_level
count  output  addr_bits+1  current occupancy, 0..2**addr_bits
overflow  output  1  sticky: a write was dropped
clr_overflow  input  1  clears overflow

Behaviour:
- Reset (async, reset_n=0) forces the following; storage contents are not reset:
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, almost_full=0, overflow=0
- Pointers are addr_bits wide and wrap from 2**addr_bits-1 to 0 with natural modulo arithmetic.
- empty, full and almost_full are registered, decoded from next-state count, so they are valid in the same cycle count updates.
- Write: wr_tick=1 and (not full, or rd=1 with full):
  - mem[wr_ptr]<=wr_data
  - wr_ptr+1
- Read: rd=1 and not empty:
  - rd_ptr+1
  - rd_data shows the next entry in the following cycle.
- rd_data = mem[rd_ptr], combinational read.
- Latency: a character written in cycle N is visible on rd_data with empty=0 in cycle N+1.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Boundary conditions:
  - rd while empty: ignored. No pointer move, no error flag.
  - wr_tick while empty with rd=1: write accepted, read ignored, count becomes 1.
  - wr_tick while full with rd=0: character dropped, overflow<=1, storage unchanged.
  - wr_tick while full with rd=1: pop and push both occur, count stays at 2**addr_bits, overflow unchanged.
  - clr_overflow and a dropped write in the same cycle: set wins, overflow=1.
  - reset_n asserted mid-operation: immediate return to the empty state; any unread characters are lost.
- wr_tick held high for more than one cycle is treated as one write per cycle. The receiver guarantees single-cycle pulses.

Decomposition:
- No shared package needed; all widths derive from parameters.
- One natural sub-module, fifo_ctrl:
  - holds the pointers, count and flags;
  - outputs write-enable, wr_addr and rd_addr.
- The top level holds the register-file array and the overflow flag.

Test Plan:
- Reset then idle: count=0, empty=1, full=0, almost_full=0, overflow=0; rd pulses leave all of these unchanged.
- Write 0x55, then next cycle: rd_data=0x55, empty=0, count=1. rd: empty=1, count=0.
- Write 16 bytes 0x00..0x0F:
  - almost_full rises on the 12th write;
  - full=1, count=16 after the 16th;
  - read all 16: values come out in order 0x00..0x0F.
- Full FIFO, wr_tick with 0xAA and rd=0: overflow=1, count=16, contents unchanged. clr_overflow: overflow=0.
- Full FIFO, wr_tick with 0xBB and rd=1 in the same cycle: count=16, overflow=0; 0xBB emerges as the 16th read after the pop.
- Wrap-around: 40 interleaved write/read cycles keeping count between 1 and 3; data order and count are exact through the pointer wraps. Assert reset_n mid-stream: empty=1 immediately.
